// File: rtl/trajectory_overlay.sv
// trajectory_overlay: double-buffered point table drawn as coloured squares over the scan position.
module trajectory_overlay #(
   parameter int NUM_POINTS = 16,
   parameter int HALF_SIZE  = 2,
   parameter int PT_IDX_W   = 4
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [10:0]         hcount_in,
   input  logic [9:0]          vcount_in,
   input  logic                pt_valid_in,
   output logic                pt_ready_out,
   input  logic [PT_IDX_W-1:0] pt_idx_in,
   input  logic [10:0]         pt_x_in,
   input  logic [9:0]          pt_y_in,
   input  logic [23:0]         pt_color_in,
   input  logic                commit_in,
   output logic                commit_pending_out,
   output logic [23:0]         trajectory_pixel_out
);
   typedef enum logic {IDLE, PENDING} state_t;
   localparam int IW = $clog2(NUM_POINTS);
   localparam logic signed [11:0] HS = 12'(HALF_SIZE);
   state_t state, state_d;
   logic [10:0] sh_x [NUM_POINTS];
   logic [9:0]  sh_y [NUM_POINTS];
   logic [23:0] sh_c [NUM_POINTS];
   logic [10:0] ac_x [NUM_POINTS];
   logic [9:0]  ac_y [NUM_POINTS];
   logic [23:0] ac_c [NUM_POINTS];
   logic [23:0] col_q [NUM_POINTS];
   logic signed [11:0] dx [NUM_POINTS];
   logic signed [11:0] dy [NUM_POINTS];
   logic [NUM_POINTS-1:0] hit, hit_q;
   logic [23:0] pix;
   logic [IW-1:0] wi;
   logic frame_start, fire, swap;

   assign frame_start        = hcount_in == '0 && vcount_in == '0;
   assign commit_pending_out = state == PENDING;
   assign pt_ready_out       = !commit_pending_out;
   assign fire               = pt_valid_in && pt_ready_out && int'(pt_idx_in) < NUM_POINTS;
   assign swap               = commit_pending_out && frame_start;
   assign wi                 = pt_idx_in[IW-1:0];

   always_comb begin
      state_d = state;
      if (state == IDLE && commit_in) state_d = PENDING;
      if (state == PENDING && frame_start) state_d = IDLE;
   end

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) state <= IDLE;
      else state <= state_d;

   // Writes are blocked while PENDING, so a swap edge never coincides with a shadow write.
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_POINTS; i++) begin
            sh_x[i] <= '0;
            sh_y[i] <= '0;
            sh_c[i] <= '0;
            ac_x[i] <= '0;
            ac_y[i] <= '0;
            ac_c[i] <= '0;
         end
      end else begin
         if (fire) begin
            sh_x[wi] <= pt_x_in;
            sh_y[wi] <= pt_y_in;
            sh_c[wi] <= pt_color_in;
         end
         if (swap) begin
            ac_x <= sh_x;
            ac_y <= sh_y;
            ac_c <= sh_c;
         end
      end

   // Signed 12-bit differences let squares clip at the screen edges instead of wrapping.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         dx[i]  = $signed({1'b0, hcount_in}) - $signed({1'b0, ac_x[i]});
         dy[i]  = $signed({2'b0, vcount_in}) - $signed({2'b0, ac_y[i]});
         hit[i] = ac_c[i] != '0 && dx[i] >= -HS && dx[i] <= HS && dy[i] >= -HS && dy[i] <= HS;
      end
   end

   always_comb begin
      pix = '0;
      for (int i = NUM_POINTS - 1; i >= 0; i--) pix = hit_q[i] ? col_q[i] : pix;
   end

   // Colours travel with the hit vector so a swap cannot mix banks within one pixel.
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         hit_q <= '0;
         for (int i = 0; i < NUM_POINTS; i++) col_q[i] <= '0;
         trajectory_pixel_out <= '0;
      end else begin
         hit_q <= hit;
         col_q <= ac_c;
         trajectory_pixel_out <= pix;
      end
endmodule

// File: doc/trajectory_overlay.md
Name: trajectory_overlay

Overview:
- Generates the 24-bit trajectory overlay pixel stream that the video mux layers over the background; a zero output means transparent.
- Holds up to NUM_POINTS predicted ball positions, each with its own colour, in a double-buffered point table.
- Loaded point-by-point over a valid/ready write port; new point sets become visible only at a frame boundary, so no frame shows a partially updated trajectory.
- Each point is drawn as a filled square centred on (x, y), compared against the current scan position with a fixed 2-cycle latency.

Parameters:
- NUM_POINTS, 16, number of point slots per bank (power of two, 2..32).
- HALF_SIZE, 2, half-width of the drawn square in pixels; square side is 2*HALF_SIZE+1.
- PT_IDX_W, 4, width of the point index (log2 NUM_POINTS).

Ports:
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous active-low reset.
- hcount_in  input  11  current scan x.
- vcount_in  input  10  current scan y.
- pt_valid_in  input  1  point write request.
- pt_ready_out  output  1  port can accept a write.
- pt_idx_in  input  PT_IDX_W  slot index.
- pt_x_in  input  11  point centre x.
- pt_y_in  input  10  point centre y.
- pt_color_in  input  24  point colour; 0 disables the slot.
- commit_in  input  1  one-cycle pulse: shadow bank complete.
- commit_pending_out  output  1  a commit is waiting for frame start.
- trajectory_pixel_out  output  24  overlay colour, or 0 for transparent.

Behaviour:
- Reset (async assert, sync release):
  - All slots of both banks cleared to x=0, y=0, colour=0.
  - trajectory_pixel_out=0, commit_pending_out=0, pipeline registers 0.
  - pt_ready_out=1 from the first edge after release.
- Write port:
  - pt_ready_out = !commit_pending_out.
  - A write fires on a rising edge with pt_valid_in && pt_ready_out and updates the shadow slot pt_idx_in.
  - Indices with pt_idx_in >= NUM_POINTS fire the handshake and are dropped.
  - The active bank is never written directly.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING on commit_in.
  - PENDING -> IDLE on a frame-start cycle (hcount_in==0 && vcount_in==0). On that edge all shadow slots are copied into the active bank. Shadow keeps its contents, so incremental updates work.
  - commit_in in PENDING is ignored.
  - commit_in and a firing write in the same cycle: the write lands first and is included in the commit.
  - commit_in on a frame-start cycle while IDLE: enters PENDING, and the swap happens at the next frame start.
  - commit_pending_out=1 exactly in PENDING.
- Pixel pipeline, latency 2 (inputs sampled at edge t produce output valid after edge t+2):
  - Stage 1: per active slot, hit = (colour != 0) && |hcount - x| <= HALF_SIZE && |vcount - y| <= HALF_SIZE.
  - Differences are computed as 12-bit signed values, so squares near x=0, y=0 or screen edges clip with no wrap-around. A point at x=1, HALF_SIZE=2 covers hcount 0..3, never 2047.
  - Stage 2: lowest-index hit wins; its colour is registered to trajectory_pixel_out, else 0.
- Swap timing vs. pipeline: pixels sampled on the frame-start cycle use the old bank; the new bank applies from the following cycle.
- Stage 1 registers the hit vector plus a copy of the candidate colours. A swap must not cause stage 2 to mix banks for one pixel.

Test Plan:
- Reset, then no writes, scan full frame -> trajectory_pixel_out=0 everywhere; pt_ready_out=1; commit_pending_out=0.
- Write slot 0 (x=100, y=50, colour 24'hFF0000), pulse commit, run to frame start, then scan -> 24'hFF0000 for hcount 98..102, vcount 48..52 (2 cycles after input), 0 elsewhere; 0 before the swap.
- Slots 3 (x=200, y=200, 00FF00) and 1 (x=201, y=200, 0000FF) overlap -> overlap region outputs 0000FF (lower index); non-overlap regions keep their own colours.
- Commit, then assert pt_valid_in during PENDING -> pt_ready_out=0, no write until after the swap; second commit_in in PENDING -> swap happens once.
- Point x=0, y=0, HALF_SIZE=2 -> coloured for hcount 0..2, vcount 0..2 only; hcount 2046/2047 and vcount 1022/1023 stay 0.
- Write pt_idx_in=NUM_POINTS with colour FFFFFF, commit -> handshake completes, no visible pixel; assert rst_n_in low mid-frame with PENDING set -> outputs 0 immediately, active bank empty after release.
